// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and parity modes, used by both RX and TX.
// Also provides the parity-check helper used by the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // data_xor is the XOR of all data bits; rx_bit is the parity bit seen on the line
  function automatic logic parity_mismatch(input logic data_xor, input logic rx_bit, input int mode);
    logic err;
    err = 1'b0;
    if (mode == PARITY_EVEN)
      err = data_xor ^ rx_bit;
    else if (mode == PARITY_ODD)
      err = ~(data_xor ^ rx_bit);
    return err;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receiver-facing bundle: serial line in, received word plus status flags out.
// No backpressure: the consumer must capture dout/flags in the rx_done_tick cycle.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 rx_done_tick;
  logic [DATA_BITS-1:0] dout;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;

  modport master (
    input  rx,
    output rx_done_tick, dout, parity_err, frame_err, break_det
  );

  modport slave (
    output rx,
    input  rx_done_tick, dout, parity_err, frame_err, break_det
  );
endinterface

// File: rtl/uart_rx_sync_vote.sv
// Two-flop synchroniser followed by a 3-tap majority filter; everything resets to idle-high.
// Single-cycle line glitches never reach the vote output.
module uart_rx_sync_vote (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic vote
);
  logic       sync1;
  logic       sync2;
  logic [2:0] taps;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      taps  <= 3'b111;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      taps  <= {taps[1:0], sync2};
    end
  end

  assign vote = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver; rx_done_tick fires 4 clk after the final stop-bit mid-point.
// No backpressure: one single-cycle tick per frame, outputs hold until the next tick.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 39,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_cfg_if.master rx_if
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int IW   = 4;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_rx_cfg: PARITY_MODE must be 0..2");
  end
  if (CLKS_PER_BIT < 8) begin : g_bad_clks
    $error("uart_rx_cfg: CLKS_PER_BIT must be >= 8");
  end

  logic vote;

  uart_rx_sync_vote u_sync_vote (
    .clk   (clk),
    .reset (reset),
    .rx    (rx_if.rx),
    .vote  (vote)
  );

  uart_state_e          state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_bit_n;
  logic                 ferr_acc, ferr_acc_n;
  logic [DATA_BITS-1:0] dout_q, dout_n;
  logic                 perr_q, perr_n;
  logic                 ferr_q, ferr_n;
  logic                 brk_q, brk_n;
  logic                 tick_q, tick_n;

  logic bit_end;
  logic ferr_now;
  logic perr_calc;
  logic brk_calc;

  assign bit_end   = (cnt == CW'(CLKS_PER_BIT - 1));
  // frame error including the stop bit being sampled right now
  assign ferr_now  = ferr_acc | ~vote;
  assign perr_calc = parity_mismatch(^shreg, par_bit, PARITY_MODE);
  assign brk_calc  = ferr_now & ~(|shreg) & ((PARITY_MODE == PARITY_NONE) | ~par_bit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
      dout_q   <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shreg    <= shreg_n;
      par_bit  <= par_bit_n;
      ferr_acc <= ferr_acc_n;
      dout_q   <= dout_n;
      perr_q   <= perr_n;
      ferr_q   <= ferr_n;
      brk_q    <= brk_n;
      tick_q   <= tick_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    shreg_n    = shreg;
    par_bit_n  = par_bit;
    ferr_acc_n = ferr_acc;
    dout_n     = dout_q;
    perr_n     = perr_q;
    ferr_n     = ferr_q;
    brk_n      = brk_q;
    tick_n     = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!vote) state_n = START;
      end

      START: begin
        if (cnt == CW'(HALF)) begin
          cnt_n = '0;
          if (!vote) begin
            state_n    = DATA;
            idx_n      = '0;
            ferr_acc_n = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shreg_n = {vote, shreg[DATA_BITS-1:1]};
          if (idx == IW'(DATA_BITS - 1)) begin
            idx_n   = '0;
            state_n = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
          end else begin
            idx_n = idx + IW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      PARITY: begin
        if (bit_end) begin
          cnt_n     = '0;
          par_bit_n = vote;
          idx_n     = '0;
          state_n   = STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          cnt_n      = '0;
          ferr_acc_n = ferr_now;
          if (idx == IW'(STOP_BITS - 1)) begin
            tick_n  = 1'b1;
            dout_n  = shreg;
            perr_n  = perr_calc;
            ferr_n  = ferr_now;
            brk_n   = brk_calc;
            idx_n   = '0;
            // a low line after a bad stop is a break or noise: don't re-arm until it idles
            state_n = ferr_now ? WAIT_HIGH : IDLE;
          end else begin
            idx_n = idx + IW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      WAIT_HIGH: begin
        cnt_n = '0;
        if (vote) state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

  assign rx_if.rx_done_tick = tick_q;
  assign rx_if.dout         = dout_q;
  assign rx_if.parity_err   = perr_q;
  assign rx_if.frame_err    = ferr_q;
  assign rx_if.break_det    = brk_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 7O2) at 16 clk/bit, table-driven frames,
// scoreboard queue checked on every rx_done_tick, plus hand-written break/glitch/reset sequences.
module tb_uart_rx_cfg;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rx_line;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         tick_cnt [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg_if #(.DATA_BITS(8)) if_8n1 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if_8e1 ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if_7o2 ();

  assign if_8n1.rx = rx_line[0];
  assign if_8e1.rx = rx_line[1];
  assign if_7o2.rx = rx_line[2];

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .rx_if(if_8n1));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .rx_if(if_8e1));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .reset(reset), .rx_if(if_7o2));

  typedef struct {
    int         sel;
    logic [8:0] dout;
    logic       pe;
    logic       fe;
    logic       bd;
    int         tick_cyc;
  } exp_t;

  typedef struct {
    int         sel;
    logic [8:0] data;
    logic       par;
    logic [1:0] stops;   // [0] = first stop bit on the line
    int         glitch;  // line bit index to glitch at its mid-point, -1 = none
    logic [8:0] exp_dout;
    logic       exp_pe;
    logic       exp_fe;
    logic       exp_bd;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];

  function automatic int db_of(input int s);
    return (s == 2) ? 7 : 8;
  endfunction
  function automatic int pm_of(input int s);
    return (s == 0) ? 0 : ((s == 1) ? 1 : 2);
  endfunction
  function automatic int sb_of(input int s);
    return (s == 2) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int sel, input logic [8:0] d, input logic pe, input logic fe,
                          input logic bd, input int tcyc);
    exp_t e;
    e.sel = sel; e.dout = d; e.pe = pe; e.fe = fe; e.bd = bd; e.tick_cyc = tcyc;
    sb.push_back(e);
  endtask

  task automatic on_tick(input int sel, input logic [8:0] d, input logic pe, input logic fe,
                         input logic bd);
    exp_t e;
    tick_cnt[sel]++;
    check("tick_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("tick_sel", sel, e.sel);
      check("dout", {23'd0, d}, {23'd0, e.dout});
      check("parity_err", {31'd0, pe}, {31'd0, e.pe});
      check("frame_err", {31'd0, fe}, {31'd0, e.fe});
      check("break_det", {31'd0, bd}, {31'd0, e.bd});
      check("tick_cycle", cyc, e.tick_cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (if_8n1.rx_done_tick)
        on_tick(0, {1'b0, if_8n1.dout}, if_8n1.parity_err, if_8n1.frame_err, if_8n1.break_det);
      if (if_8e1.rx_done_tick)
        on_tick(1, {1'b0, if_8e1.dout}, if_8e1.parity_err, if_8e1.frame_err, if_8e1.break_det);
      if (if_7o2.rx_done_tick)
        on_tick(2, {2'b0, if_7o2.dout}, if_7o2.parity_err, if_7o2.frame_err, if_7o2.break_det);
    end
  end

  // A line bit is taken to start at the first clk edge that can capture it, so the tick is
  // expected (bit_start + N*CPB + CPB/2 + 4) where N is the index of the final stop bit.
  // The line is left at the last bit's value; callers restore idle.
  task automatic send_frame(input int sel, input logic [8:0] data, input logic par,
                            input logic [1:0] stops, input int glitch, input logic [8:0] exp_d,
                            input logic exp_pe, input logic exp_fe, input logic exp_bd);
    logic [12:0] bits;
    int          nb;
    bits = '0;
    for (int i = 0; i < db_of(sel); i++) bits[1+i] = data[i];
    nb = 1 + db_of(sel);
    if (pm_of(sel) != 0) begin
      bits[nb] = par;
      nb++;
    end
    for (int s = 0; s < sb_of(sel); s++) begin
      bits[nb] = stops[s];
      nb++;
    end
    @(posedge clk); #1;
    push_exp(sel, exp_d, exp_pe, exp_fe, exp_bd, cyc + 1 + (nb - 1) * CPB + CPB / 2 + 4);
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < CPB; c++) begin
        rx_line[sel] = (b == glitch && c == CPB / 2) ? ~bits[b] : bits[b];
        @(posedge clk); #1;
      end
    end
    rx_line[sel] = bits[nb-1];
  endtask

  task automatic idle_line(input int sel, input int periods);
    rx_line[sel] = 1'b1;
    repeat (periods * CPB) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 * CPB && sb.size() != 0; i++) @(posedge clk);
    #1;
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;

    vecs[0]  = '{0, 9'h0A5, 1'b0, 2'b11, -1, 9'h0A5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{0, 9'h000, 1'b0, 2'b11, -1, 9'h000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{0, 9'h03C, 1'b0, 2'b11,  4, 9'h03C, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{0, 9'h0C3, 1'b0, 2'b10, -1, 9'h0C3, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1, 9'h037, 1'b0, 2'b11, -1, 9'h037, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1, 9'h037, 1'b1, 2'b11, -1, 9'h037, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1, 9'h000, 1'b1, 2'b11, -1, 9'h000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1, 9'h000, 1'b0, 2'b10, -1, 9'h000, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{2, 9'h015, 1'b0, 2'b11, -1, 9'h015, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{2, 9'h015, 1'b1, 2'b11, -1, 9'h015, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{2, 9'h000, 1'b0, 2'b00, -1, 9'h000, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{2, 9'h041, 1'b1, 2'b10, -1, 9'h041, 1'b0, 1'b1, 1'b0};

    for (int k = 0; k < 3; k++) tick_cnt[k] = 0;
    reset   = 1'b1;
    rx_line = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tick_8n1", if_8n1.rx_done_tick, 0);
    check("rst_dout_8n1", if_8n1.dout, 0);
    check("rst_flags_8n1", {if_8n1.parity_err, if_8n1.frame_err, if_8n1.break_det}, 0);
    check("rst_tick_8e1", if_8e1.rx_done_tick, 0);
    check("rst_dout_8e1", if_8e1.dout, 0);
    check("rst_flags_8e1", {if_8e1.parity_err, if_8e1.frame_err, if_8e1.break_det}, 0);
    check("rst_tick_7o2", if_7o2.rx_done_tick, 0);
    check("rst_dout_7o2", if_7o2.dout, 0);
    check("rst_flags_7o2", {if_7o2.parity_err, if_7o2.frame_err, if_7o2.break_det}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2 * CPB) @(posedge clk);

    for (int v = 0; v < 12; v++) begin
      send_frame(vecs[v].sel, vecs[v].data, vecs[v].par, vecs[v].stops, vecs[v].glitch,
                 vecs[v].exp_dout, vecs[v].exp_pe, vecs[v].exp_fe, vecs[v].exp_bd);
      idle_line(vecs[v].sel, 2);
    end
    wait_drain("table_drained");

    // 7O2 with the second stop bit low, line then held low: must sit in WAIT_HIGH
    t0 = tick_cnt[2];
    send_frame(2, 9'h041, 1'b1, 2'b01, -1, 9'h041, 1'b0, 1'b1, 1'b0);
    rx_line[2] = 1'b0;
    repeat (12 * CPB) @(posedge clk);
    #1;
    check("wait_high_one_tick", tick_cnt[2], t0 + 1);
    idle_line(2, 2);
    check("wait_high_no_retrigger", tick_cnt[2], t0 + 1);
    send_frame(2, 9'h02A, 1'b0, 2'b11, -1, 9'h02A, 1'b0, 1'b0, 1'b0);
    idle_line(2, 2);

    // 8N1 line break for 20 bit periods
    t0 = tick_cnt[0];
    @(posedge clk); #1;
    push_exp(0, 9'h000, 1'b0, 1'b1, 1'b1, cyc + 1 + 9 * CPB + CPB / 2 + 4);
    rx_line[0] = 1'b0;
    repeat (20 * CPB) @(posedge clk);
    #1;
    check("break_one_tick", tick_cnt[0], t0 + 1);
    idle_line(0, 3);
    check("break_no_retrigger", tick_cnt[0], t0 + 1);
    send_frame(0, 9'h05A, 1'b0, 2'b11, -1, 9'h05A, 1'b0, 1'b0, 1'b0);
    idle_line(0, 2);

    // 3-clk low pulse on an idle line is not a start bit
    t0 = tick_cnt[0];
    @(posedge clk); #1;
    rx_line[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle_line(0, 2);
    check("short_pulse_no_tick", tick_cnt[0], t0);
    wait_drain("seq_drained");

    // reset pulse in data bit 4 of 0xFF: frame dropped, outputs back to reset values
    t0 = tick_cnt[0];
    @(posedge clk); #1;
    rx_line[0] = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    rx_line[0] = 1'b1;
    repeat (4 * CPB + CPB / 2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6 * CPB) @(posedge clk);
    @(negedge clk);
    check("reset_midframe_no_tick", tick_cnt[0], t0);
    check("reset_midframe_dout", if_8n1.dout, 0);
    send_frame(0, 9'h012, 1'b0, 2'b11, -1, 9'h012, 1'b0, 1'b0, 1'b0);
    idle_line(0, 2);
    wait_drain("final_drained");
    check("post_reset_tick", tick_cnt[0], t0 + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
